// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct constants, loader mnemonics, and the
// loader FSM state type.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   typedef enum logic [3:0] {
      MN_R       = 4'd0,
      MN_JR      = 4'd1,
      MN_J       = 4'd2,
      MN_JAL     = 4'd3,
      MN_BEQ     = 4'd4,
      MN_BNE     = 4'd5,
      MN_ADDI    = 4'd6,
      MN_SLTI    = 4'd7,
      MN_SLTIU   = 4'd8,
      MN_ANDI    = 4'd9,
      MN_ORI     = 4'd10,
      MN_XORI    = 4'd11,
      MN_LUI     = 4'd12,
      MN_LW      = 4'd13,
      MN_SW      = 4'd14,
      MN_ILLEGAL = 4'd15
   } mnemonic_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_FULL
   } state_e;

endpackage

// File: rtl/mips_encoder.sv
// Combinational mnemonic-fields to 32-bit MIPS word encoder with illegal flag.
module mips_encoder
   import mips_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (mnemonic_e'(op))
         // An R-type carrying the JR funct must go through the JR mnemonic.
         MN_R: begin
            word    = {OP_RTYPE, rs, rt, rd, shamt, funct};
            illegal = (funct == FUNCT_JR);
         end
         MN_JR:    word = {OP_RTYPE, rs, 15'b0, FUNCT_JR};
         MN_J:     word = {OP_J, target};
         MN_JAL:   word = {OP_JAL, target};
         MN_BEQ:   word = {OP_BEQ, rs, rt, imm};
         MN_BNE:   word = {OP_BNE, rs, rt, imm};
         MN_ADDI:  word = {OP_ADDI, rs, rt, imm};
         MN_SLTI:  word = {OP_SLTI, rs, rt, imm};
         MN_SLTIU: word = {OP_SLTIU, rs, rt, imm};
         MN_ANDI:  word = {OP_ANDI, rs, rt, imm};
         MN_ORI:   word = {OP_ORI, rs, rt, imm};
         MN_XORI:  word = {OP_XORI, rs, rt, imm};
         MN_LUI:   word = {OP_LUI, 5'b0, rt, imm};
         MN_LW:    word = {OP_LW, rs, rt, imm};
         MN_SW:    word = {OP_SW, rs, rt, imm};
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_instr_loader.sv
// Program loader: accepts instruction fields, encodes them and writes the
// words sequentially into instruction memory over a req/ack port.
module mips_instr_loader
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned DEPTH     = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              imem_ack,
   output logic [ADDR_W:0]   load_count,
   output logic              full,
   output logic              err_illegal
);

   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_e            state, state_n;
   logic [31:0]       word_q;
   logic [ADDR_W:0]   count_q;
   logic              err_q;
   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic              take;
   logic              take_legal;
   logic              take_illegal;
   logic              write_done;
   logic [ADDR_W:0]   count_inc;

   mips_encoder u_encoder (
      .op      (in_op),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .shamt   (in_shamt),
      .funct   (in_funct),
      .imm     (in_imm),
      .target  (in_target),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_n      = state;
      take         = 1'b0;
      take_legal   = 1'b0;
      take_illegal = 1'b0;
      write_done   = 1'b0;
      if (start) begin
         state_n = S_ACCEPT;
      end else begin
         case (state)
            S_IDLE:   state_n = S_IDLE;
            S_ACCEPT: begin
               take         = in_valid;
               take_legal   = in_valid && !enc_illegal;
               take_illegal = in_valid && enc_illegal;
               if (take_legal) state_n = S_WRITE;
            end
            S_WRITE: begin
               write_done = imem_ack;
               if (imem_ack) state_n = (count_inc == DEPTH_C) ? S_FULL : S_ACCEPT;
            end
            S_FULL:   state_n = S_FULL;
            default:  state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         word_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_n;
         if (take_legal) word_q <= enc_word;
         if (start) begin
            count_q <= '0;
            err_q   <= 1'b0;
         end else begin
            if (write_done)   count_q <= count_inc;
            if (take_illegal) err_q   <= 1'b1;
         end
      end
   end

   assign in_ready    = (state == S_ACCEPT);
   assign imem_we     = (state == S_WRITE);
   assign imem_addr   = BASE_C + count_q[ADDR_W-1:0];
   assign imem_wdata  = word_q;
   assign load_count  = count_q;
   assign full        = (count_q == DEPTH_C);
   assign err_illegal = err_q;

endmodule

// File: tb/tb_mips_instr_loader.sv
// Directed bench for mips_instr_loader: spec-level cycle model, per-cycle
// compare, write log, and literal checks on encoded words and addresses.
module tb_mips_instr_loader;

   localparam int ADDR_W = 8;
   localparam int BASE   = 0;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_op = '0;
   logic [4:0]        in_rs = '0;
   logic [4:0]        in_rt = '0;
   logic [4:0]        in_rd = '0;
   logic [4:0]        in_shamt = '0;
   logic [5:0]        in_funct = '0;
   logic [15:0]       in_imm = '0;
   logic [25:0]       in_target = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              imem_ack = 1'b0;
   logic [ADDR_W:0]   load_count;
   logic              full;
   logic              err_illegal;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mips_instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
      .load_count(load_count), .full(full), .err_illegal(err_illegal)
   );

   // Spec-level encoding: returns {illegal, word}.
   function automatic logic [32:0] ref_encode(input int op, input int rs, input int rt,
                                              input int rd, input int sh, input int fn,
                                              input int imm, input int tg);
      int opc;
      int itype;
      itype = (rs << 21) | (rt << 16) | imm;
      case (op)
         0:  return {(fn == 8), 32'((rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn)};
         1:  return {1'b0, 32'((rs << 21) | 8)};
         2:  return {1'b0, 32'((2 << 26) | tg)};
         3:  return {1'b0, 32'((3 << 26) | tg)};
         12: return {1'b0, 32'((15 << 26) | (rt << 16) | imm)};
         15: return {1'b1, 32'd0};
         default: begin
            case (op)
               4: opc = 4;   5: opc = 5;   6: opc = 8;   7: opc = 10;
               8: opc = 11;  9: opc = 12;  10: opc = 13; 11: opc = 14;
               13: opc = 35; default: opc = 43;
            endcase
            return {1'b0, 32'((opc << 26) | itype)};
         end
      endcase
   endfunction

   // Model: armed = loader takes fields when not holding a word; pend = word awaiting ack.
   bit          m_armed, m_pend, m_err;
   int          m_cnt;
   logic [31:0] m_word;
   logic [32:0] m_enc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_armed = 0; m_pend = 0; m_err = 0; m_cnt = 0; m_word = '0;
      end else if (start) begin
         m_armed = 1; m_pend = 0; m_err = 0; m_cnt = 0;
      end else if (m_pend) begin
         if (imem_ack) begin
            m_pend = 0;
            m_cnt  = m_cnt + 1;
            if (m_cnt == DEPTH) m_armed = 0;
         end
      end else if (m_armed && in_valid) begin
         m_enc = ref_encode(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt),
                            int'(in_funct), int'(in_imm), int'(in_target));
         if (m_enc[32]) m_err = 1;
         else begin
            m_pend = 1;
            m_word = m_enc[31:0];
         end
      end
   end

   // Log of writes the memory accepted.
   logic [ADDR_W-1:0] log_addr [0:15];
   logic [31:0]       log_data [0:15];
   int                log_n = 0;

   always @(posedge clk) begin
      if (rst_n && imem_we && imem_ack && !start && log_n < 16) begin
         log_addr[log_n] = imem_addr;
         log_data[log_n] = imem_wdata;
         log_n = log_n + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("in_ready",    32'(in_ready),    32'(m_armed && !m_pend));
      check("imem_we",     32'(imem_we),     32'(m_pend));
      check("imem_addr",   32'(imem_addr),   32'((BASE + m_cnt) % (1 << ADDR_W)));
      check("imem_wdata",  imem_wdata,       m_word);
      check("load_count",  32'(load_count),  32'(m_cnt));
      check("full",        32'(full),        32'(m_cnt == DEPTH));
      check("err_illegal", 32'(err_illegal), 32'(m_err));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic offer(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg);
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_funct = fn; in_imm = imm; in_target = tg;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) step();
      check("handshake_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic ack_after(input int d);
      check("we_before_ack", 32'(imem_we), 32'd1);
      repeat (d) step();
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
   endtask

   task automatic check_log(input int idx, input int addr, input logic [31:0] data);
      check($sformatf("log%0d_addr", idx), 32'(log_addr[idx]), 32'(addr));
      check($sformatf("log%0d_data", idx), log_data[idx], data);
   endtask

   initial begin
      fork
         begin
            forever begin
               @(negedge clk);
               if (chk_en) compare_all();
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
         end
         begin
            repeat (3) step();
            check("rst_ready", 32'(in_ready), 32'd0);
            check("rst_we",    32'(imem_we),  32'd0);
            check("rst_addr",  32'(imem_addr), 32'd0);
            check("rst_wdata", imem_wdata,    32'd0);
            check("rst_count", 32'(load_count), 32'd0);
            rst_n = 1'b1;
            chk_en = 1'b1;
            step();
            step();
            check("idle_ready", 32'(in_ready), 32'd0);

            // ADDI rs=1 rt=2 imm=5, immediate ack.
            pulse_start();
            offer(4'd6, 5'd1, 5'd2, 5'd9, 5'd9, 6'h3F, 16'h0005, 26'h3FFFFFF);
            ack_after(0);
            check("addi_count", 32'(load_count), 32'd1);

            // R / JAL / LUI with unused fields set to junk; LUI ack stalled 3 cycles.
            pulse_start();
            offer(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'hFFFF, 26'h3FFFFFF);
            ack_after(0);
            offer(4'd3, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010);
            ack_after(0);
            offer(4'd12, 5'd7, 5'd4, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h3FFFFFF);
            ack_after(3);
            check("stall_count", 32'(load_count), 32'd3);

            // Illegal op and R-with-JR-funct, then JR.
            pulse_start();
            offer(4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1);
            check("err_after_op15", 32'(err_illegal), 32'd1);
            offer(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001000, 16'd0, 26'd0);
            check("illegal_count", 32'(load_count), 32'd0);
            offer(4'd1, 5'd31, 5'd5, 5'd6, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
            ack_after(0);
            check("jr_err_sticky", 32'(err_illegal), 32'd1);

            // Fill to DEPTH, offers refused while full, then restart.
            pulse_start();
            check("start_clears_err", 32'(err_illegal), 32'd0);
            for (int k = 0; k < 4; k++) begin
               offer(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(k), 26'd0);
               ack_after(0);
            end
            check("full_flag",  32'(full),       32'd1);
            check("full_count", 32'(load_count), 32'd4);
            in_valid = 1'b1;
            repeat (3) step();
            check("full_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b0;
            pulse_start();
            check("restart_count", 32'(load_count), 32'd0);
            offer(4'd14, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0);
            ack_after(1);

            // start coincident with ack: word dropped.
            pulse_start();
            offer(4'd6, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0777, 26'd0);
            start = 1'b1;
            imem_ack = 1'b1;
            step();
            start = 1'b0;
            imem_ack = 1'b0;
            check("startack_we",    32'(imem_we),    32'd0);
            check("startack_count", 32'(load_count), 32'd0);

            // Asynchronous reset mid-WRITE.
            offer(4'd10, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h00F0, 26'd0);
            #2;
            rst_n = 1'b0;
            #1;
            check("arst_ready", 32'(in_ready),    32'd0);
            check("arst_we",    32'(imem_we),     32'd0);
            check("arst_addr",  32'(imem_addr),   32'd0);
            check("arst_wdata", imem_wdata,       32'd0);
            check("arst_count", 32'(load_count),  32'd0);
            check("arst_full",  32'(full),        32'd0);
            check("arst_err",   32'(err_illegal), 32'd0);
            @(negedge clk);
            #1;
            rst_n = 1'b1;
            step();

            // Literal expectations for everything written.
            check("log_count", 32'(log_n), 32'd10);
            check_log(0, 0, 32'h20220005);
            check_log(1, 0, 32'h00221820);
            check_log(2, 1, 32'h0C000010);
            check_log(3, 2, 32'h3C041234);
            check_log(4, 0, 32'h03E00008);
            for (int k = 0; k < 4; k++) check_log(5 + k, k, 32'h20010000 + 32'(k));
            check_log(9, 0, 32'hAFA8FFFC);
         end
      join_any
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
